data_mem_block_mover: RTL and testbench
=======================================

# data_mem_block_mover

Initiator-side engine for the single-port data memory. It copies a block of `len` words from `src` to `dst` within the memory using one word read followed by one word write, and accumulates a 16-bit checksum of the transferred data. It sits between the control/test logic and the data memory's `A`/`WD`/`we`/`RD` port, and owns that port whenever `busy` is high.

## Interface
- `DEPTH`, 100: number of memory words; valid addresses are 0..DEPTH-1.
- `AW`, 32: memory address width.
- `DW`, 32: memory data width.
- `LW`, 8: width of the `len` input.

- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request pulse; sampled only in IDLE.
- `src`  in  AW  first source word address; sampled with `start`.
- `dst`  in  AW  first destination word address; sampled with `start`.
- `len`  in  LW  number of words to copy; sampled with `start`.
- `mem_a`  out  AW  memory address.
- `mem_wd`  out  DW  memory write data.
- `mem_we`  out  1  memory write enable.
- `mem_rd`  in  DW  memory read data, combinational from `mem_a`.
- `busy`  out  1  high in READ and WRITE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  last accepted request was rejected; held until the next accepted start.
- `sum`  out  16  sum mod 2^16 of `mem_rd[15:0]` over all words read by the last request.

## Operation
- States: IDLE, READ, WRITE, DONE.
- **IDLE**
  - `start`=1 latches `src`, `dst` and `len` into pointers and a remaining counter, and clears `sum` and `err`.
  - If `src>=DEPTH`, `dst>=DEPTH` or `len>DEPTH`: set `err`=1 and go to DONE. No memory access occurs.
  - Otherwise, if `len`=0: go to DONE.
  - Otherwise: go to READ.
- **READ**
  - `mem_a`=src pointer, `mem_we`=0.
  - At the edge: capture `mem_rd` into the data buffer and add `mem_rd[15:0]` to `sum`. Go to WRITE.
- **WRITE**
  - `mem_a`=dst pointer, `mem_wd`=buffer, `mem_we`=1.
  - At the edge: advance both pointers and decrement the remaining counter.
  - If the remaining count becomes 0, go to DONE; otherwise go to READ.
- **DONE**
  - `done`=1 for this one cycle, then go to IDLE.
- Pointer advance wraps from DEPTH-1 to 0 (increment with compare, no modulo operator).
- `start` outside IDLE is ignored and is not queued.
- Copy order is strictly ascending, and write i completes before read i+1. Overlapping regions are therefore defined: for example, `dst`=`src`+1 replicates `mem[src]` across the whole destination block.
- `sum` width rule: 16-bit wrap-around addition. Carries are discarded.
- Outputs in IDLE and DONE: `mem_a`=0, `mem_wd`=0, `mem_we`=0.
- `mem_*`, `busy` and `done` decode from registers only. There is no combinational path from any input to any output.

## Timing
- Reset (async, any state): state goes to IDLE. `mem_we`, `busy`, `done` and `err` go to 0 immediately; `mem_a`, `mem_wd` and `sum` go to 0.
- A reset mid-transfer abandons the transfer. Words already written remain in memory.
- Start accepted at edge 0:
  - Cycles 1..2·len alternate READ and WRITE.
  - `done` is high in cycle 2·len+1.
  - IDLE is reached in cycle 2·len+2, where a new `start` is accepted.
- len=0 or a rejected request: `done` is high in cycle 1, and `busy` never rises.
- Throughput: 2 cycles per word, plus 2 cycles of overhead per request.

## Structure
- Shared package holds:
  - the state enum (IDLE/READ/WRITE/DONE);
  - the DEPTH default constant.
  - The data memory's depth must match DEPTH, so the same constant is used there.
- One sub-module, `wrap_ptr`: a loadable AW-bit pointer with an increment that wraps at DEPTH-1. It is instantiated twice, for src and dst.

## Test plan
- Memory holds mem[i]=i+1 for i=0..9. Request src=0, dst=20, len=4. Expected: mem[20..23]=1,2,3,4; `sum`=10; `done` in cycle 9; `mem_we` high in cycles 2,4,6,8 only.
- src=98, dst=10, len=4, with mem[98]=5, mem[99]=6, mem[0]=7, mem[1]=8. Expected: reads wrap to 0, mem[10..13]=5,6,7,8, `sum`=26.
- Overlap case: src=0, dst=1, len=3, mem[0]=0xAB. Expected: mem[1..3]=0xAB; `sum`=0x201, since 0xAB·3 = 0x201.
- len=0 gives `done` in cycle 1 with no `mem_we`. dst=100 gives `err`=1 and `done` in cycle 1 with no access. A following valid start clears `err`.
- Data 0xFFFF in 2 words gives `sum`=0xFFFE (wrap). `start` pulsed while `busy` has no effect on pointers or `len`.
- Assert `rst`=0 in the first WRITE cycle of a len=4 request. Expected: `mem_we` drops asynchronously, `busy`=0, `sum`=0, no `done`; after release the block accepts a new start.

Source files
------------

// File: rtl/data_mem_block_mover_pkg.sv
// Shared definitions for the data memory block mover: FSM states and the
// memory depth that both the mover and the data memory are built with.
package data_mem_block_mover_pkg;

  localparam int unsigned DEPTH_DEFAULT = 100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_DONE
  } state_e;

endpackage

// File: rtl/data_mem_block_mover_wrap_ptr.sv
// Loadable word pointer whose increment wraps from DEPTH-1 back to 0.
module wrap_ptr
  import data_mem_block_mover_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_d, ptr_q;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    ptr_d = ptr_q;
    if (load) begin
      ptr_d = load_val;
    end else if (inc) begin
      ptr_d = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ptr_q <= '0;
    else      ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/data_mem_block_mover.sv
// Copies len words from src to dst inside the single-port data memory, one
// read then one write per word, accumulating a 16-bit checksum of the data.
module data_mem_block_mover
  import data_mem_block_mover_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEFAULT,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32,
  parameter int unsigned LW    = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] src,
  input  logic [AW-1:0] dst,
  input  logic [LW-1:0] len,
  output logic [AW-1:0] mem_a,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [15:0]   sum
);

  state_e        state_d, state_q;
  logic [DW-1:0] buf_d, buf_q;
  logic [LW-1:0] rem_d, rem_q;
  logic [15:0]   sum_d, sum_q;
  logic          err_d, err_q;
  logic          ptr_load, ptr_inc;
  logic          req_bad;
  logic [AW-1:0] src_ptr, dst_ptr;

  assign req_bad = (src >= AW'(DEPTH)) || (dst >= AW'(DEPTH)) ||
                   (32'(len) > 32'(DEPTH));

  always_comb begin
    state_d  = state_q;
    buf_d    = buf_q;
    rem_d    = rem_q;
    sum_d    = sum_q;
    err_d    = err_q;
    ptr_load = 1'b0;
    ptr_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          ptr_load = 1'b1;
          rem_d    = len;
          sum_d    = '0;
          err_d    = req_bad;
          if (req_bad || len == '0) state_d = ST_DONE;
          else                      state_d = ST_READ;
        end
      end
      ST_READ: begin
        buf_d   = mem_rd;
        sum_d   = sum_q + mem_rd[15:0];
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        ptr_inc = 1'b1;
        rem_d   = rem_q - LW'(1);
        state_d = (rem_q == LW'(1)) ? ST_DONE : ST_READ;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      buf_q   <= '0;
      rem_q   <= '0;
      sum_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      rem_q   <= rem_d;
      sum_q   <= sum_d;
      err_q   <= err_d;
    end
  end

  wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_src_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .load_val (src),
    .inc      (ptr_inc),
    .ptr      (src_ptr)
  );

  wrap_ptr #(.DEPTH(DEPTH), .AW(AW)) u_dst_ptr (
    .clk      (clk),
    .rst      (rst),
    .load     (ptr_load),
    .load_val (dst),
    .inc      (ptr_inc),
    .ptr      (dst_ptr)
  );

  // Port outputs decode from state and pointer flops only, so an async
  // reset releases the memory port immediately.
  assign mem_a  = (state_q == ST_READ)  ? src_ptr :
                  (state_q == ST_WRITE) ? dst_ptr : '0;
  assign mem_wd = (state_q == ST_WRITE) ? buf_q : '0;
  assign mem_we = (state_q == ST_WRITE);
  assign busy   = (state_q == ST_READ) || (state_q == ST_WRITE);
  assign done   = (state_q == ST_DONE);
  assign err    = err_q;
  assign sum    = sum_q;

endmodule

// File: tb/tb_data_mem_block_mover.sv
// Randomized bench for data_mem_block_mover against a sequential copy model
// of the data memory, plus the directed boundary cases.
module tb_data_mem_block_mover;
  import data_mem_block_mover_pkg::*;

  localparam int DEPTH = DEPTH_DEFAULT;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LW = 8;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] src, dst;
  logic [LW-1:0] len;
  logic [AW-1:0] mem_a;
  logic [DW-1:0] mem_wd, mem_rd;
  logic          mem_we, busy, done, err;
  logic [15:0]   sum;

  logic [DW-1:0] mem     [DEPTH];
  logic [DW-1:0] ref_mem [DEPTH];

  int n_cmp = 0;
  int n_bad = 0;

  data_mem_block_mover #(.DEPTH(DEPTH), .AW(AW), .DW(DW), .LW(LW)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .src    (src),
    .dst    (dst),
    .len    (len),
    .mem_a  (mem_a),
    .mem_wd (mem_wd),
    .mem_we (mem_we),
    .mem_rd (mem_rd),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .sum    (sum)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd = (mem_a < AW'(DEPTH)) ? mem[int'(mem_a)] : '0;

  always @(posedge clk) begin
    if (mem_we && mem_a < AW'(DEPTH)) mem[int'(mem_a)] <= mem_wd;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Poke a word into both the environment memory and the model (idle only).
  task automatic put_word(input int a, input logic [DW-1:0] v);
    mem[a]     = v;
    ref_mem[a] = v;
  endtask

  task automatic check_mem(input string tag);
    int diffs = 0;
    for (int i = 0; i < DEPTH; i++) if (mem[i] !== ref_mem[i]) diffs++;
    check({tag, "_mem"}, 32'(diffs), 32'd0);
  endtask

  // Reference: a plain ascending word-by-word copy with modulo addressing.
  task automatic model_req(input logic [AW-1:0] s, input logic [AW-1:0] d,
                           input logic [LW-1:0] l,
                           output bit exp_err, output logic [15:0] exp_sum);
    exp_sum = 16'd0;
    exp_err = (s >= AW'(DEPTH)) || (d >= AW'(DEPTH)) || (int'(l) > DEPTH);
    if (!exp_err) begin
      for (int i = 0; i < int'(l); i++) begin
        int si = (int'(s) + i) % DEPTH;
        int di = (int'(d) + i) % DEPTH;
        exp_sum     = exp_sum + ref_mem[si][15:0];
        ref_mem[di] = ref_mem[si];
      end
    end
  endtask

  task automatic run_req(input string tag, input logic [AW-1:0] s,
                         input logic [AW-1:0] d, input logic [LW-1:0] l,
                         input bit poke);
    bit          exp_err;
    logic [15:0] exp_sum;
    int          nwords, exp_done_cyc, done_cyc, we_bad, busy_bad;
    model_req(s, d, l, exp_err, exp_sum);
    nwords       = exp_err ? 0 : int'(l);
    exp_done_cyc = 2 * nwords + 1;
    done_cyc = 0; we_bad = 0; busy_bad = 0;
    @(negedge clk);
    start = 1'b1; src = s; dst = d; len = l;
    @(posedge clk); #1;
    start = 1'b0; src = $urandom; dst = $urandom; len = LW'($urandom);
    for (int cyc = 1; cyc <= exp_done_cyc + 1; cyc++) begin
      bit exp_we   = (cyc >= 2) && (cyc <= 2 * nwords) && (cyc % 2 == 0);
      bit exp_busy = (cyc <= 2 * nwords);
      if (mem_we !== exp_we) we_bad++;
      if (busy !== exp_busy) busy_bad++;
      if (done === 1'b1) begin
        if (done_cyc == 0) done_cyc = cyc;
        else               done_cyc = -1;
      end
      start = 1'b0;
      if (poke && cyc == 3) begin
        start = 1'b1; src = AW'(7); dst = AW'(8); len = LW'(1);
      end
      if (cyc <= exp_done_cyc) begin
        @(posedge clk); #1;
      end
    end
    check({tag, "_done_cyc"}, 32'(done_cyc), 32'(exp_done_cyc));
    check({tag, "_we_pattern"}, 32'(we_bad), 32'd0);
    check({tag, "_busy_pattern"}, 32'(busy_bad), 32'd0);
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_sum"}, 32'(sum), 32'(exp_sum));
    check_mem(tag);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; src = '0; dst = '0; len = '0;
    for (int i = 0; i < DEPTH; i++) put_word(i, $urandom);
    for (int i = 0; i < 10; i++) put_word(i, DW'(i + 1));
    #12;
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_mem_a", mem_a, 32'd0);
    @(negedge clk); rst = 1'b1;

    run_req("basic", 32'd0, 32'd20, 8'd4, 1'b0);
    check("basic_sum_lit", 32'(sum), 32'd10);

    @(negedge clk);
    put_word(98, 5); put_word(99, 6); put_word(0, 7); put_word(1, 8);
    run_req("wrap", 32'd98, 32'd10, 8'd4, 1'b0);
    check("wrap_sum_lit", 32'(sum), 32'd26);

    @(negedge clk);
    put_word(0, 32'hAB);
    run_req("overlap", 32'd0, 32'd1, 8'd3, 1'b0);
    check("overlap_sum_lit", 32'(sum), 32'h201);

    run_req("len0", 32'd5, 32'd50, 8'd0, 1'b0);
    run_req("bad_dst", 32'd5, 32'd100, 8'd3, 1'b0);
    check("bad_dst_err_lit", 32'(err), 32'd1);
    run_req("clear_err", 32'd2, 32'd60, 8'd2, 1'b0);
    check("clear_err_lit", 32'(err), 32'd0);
    run_req("bad_len", 32'd0, 32'd0, 8'd101, 1'b0);

    @(negedge clk);
    put_word(30, 32'h0000_FFFF); put_word(31, 32'h1234_FFFF);
    run_req("sum_wrap", 32'd30, 32'd40, 8'd2, 1'b0);
    check("sum_wrap_lit", 32'(sum), 32'hFFFE);

    run_req("busy_start", 32'd70, 32'd80, 8'd5, 1'b1);

    // Reset during the first WRITE cycle abandons the transfer.
    @(negedge clk);
    start = 1'b1; src = 32'd50; dst = 32'd60; len = 8'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_pre_we", 32'(mem_we), 32'd1);
    #1 rst = 1'b0;
    #1;
    check("mid_rst_we", 32'(mem_we), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    check_mem("mid_rst");
    run_req("after_rst", 32'd50, 32'd60, 8'd4, 1'b0);

    for (int k = 0; k < 12; k++) begin
      logic [AW-1:0] rs, rd;
      logic [LW-1:0] rl;
      @(negedge clk);
      for (int i = 0; i < 8; i++) put_word($urandom_range(0, DEPTH - 1), $urandom);
      rs = AW'($urandom_range(0, 104));
      rd = AW'($urandom_range(0, 104));
      rl = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(95, 120))
                                       : LW'($urandom_range(0, 12));
      run_req($sformatf("rand%0d", k), rs, rd, rl, ($urandom_range(0, 1) == 1) && rl >= 2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
